// File: rtl/accum64_pkg.sv
// Shared types and helpers for the accum64 streaming accumulator.
// Build option: define ACCUM64_SAT_EN to saturate the running total on carry-out.
package accum64_pkg;

    typedef enum logic [0:0] {
        ST_ACC  = 1'b0,
        ST_HOLD = 1'b1
    } state_e;

    localparam logic [63:0] SAT_ONES = 64'hFFFF_FFFF_FFFF_FFFF;

    // Increment by one when inc is set, sticking at max_val; callers pass counters up to 32 bits wide.
    function automatic logic [31:0] sat_inc(input logic [31:0] val,
                                            input logic [31:0] max_val,
                                            input logic        inc);
        logic [31:0] res;
        if (inc && (val != max_val)) begin
            res = val + 32'd1;
        end else begin
            res = val;
        end
        return res;
    endfunction

endpackage

// File: rtl/adder64.sv
// Combinational 64-bit unsigned adder with carry-out.
module adder64 (
    input  logic [63:0] A,
    input  logic [63:0] B,
    output logic [63:0] S,
    output logic        C64
);

    assign {C64, S} = {1'b0, A} + {1'b0, B};

endmodule

// File: rtl/accum64.sv
// Packet reduction stage: folds a stream of 64-bit operands into a total, operand count and carry count.
// Build option: ACCUM64_SAT_EN makes any carry-out pin the total at all-ones for the rest of the packet.
module accum64
    import accum64_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [63:0]      in_data,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [63:0]      out_sum,
    output logic [CNT_W-1:0] out_count,
    output logic [CNT_W-1:0] out_carries
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_e           state_q, state_d;
    logic [63:0]      acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] cry_q, cry_d;
    logic             out_valid_q, out_valid_d;
    logic [63:0]      out_sum_q, out_sum_d;
    logic [CNT_W-1:0] out_count_q, out_count_d;
    logic [CNT_W-1:0] out_carries_q, out_carries_d;

    logic [63:0]      add_s;
    logic             add_c;
    logic             accept_s;
    logic [31:0]      cnt_inc_s;
    logic [31:0]      cry_inc_s;

    adder64 u_adder (
        .A   (acc_q),
        .B   (in_data),
        .S   (add_s),
        .C64 (add_c)
    );

    assign in_ready = (state_q == ST_ACC);
    assign accept_s = in_valid & in_ready;

    // Next-state, accumulator update and result capture.
    always_comb begin
        state_d       = state_q;
        acc_d         = acc_q;
        cnt_d         = cnt_q;
        cry_d         = cry_q;
        out_valid_d   = out_valid_q;
        out_sum_d     = out_sum_q;
        out_count_d   = out_count_q;
        out_carries_d = out_carries_q;
        cnt_inc_s     = sat_inc(32'(cnt_q), 32'(CNT_MAX), 1'b1);
        cry_inc_s     = sat_inc(32'(cry_q), 32'(CNT_MAX), add_c);

        case (state_q)
            ST_ACC: begin
                if (accept_s) begin
`ifdef ACCUM64_SAT_EN
                    acc_d = add_c ? SAT_ONES : add_s;
`else
                    acc_d = add_s;
`endif
                    cnt_d = CNT_W'(cnt_inc_s);
                    cry_d = CNT_W'(cry_inc_s);
                    if (in_last) begin
                        // Results are captured from the post-update values so they appear one cycle later.
                        state_d       = ST_HOLD;
                        out_valid_d   = 1'b1;
                        out_sum_d     = acc_d;
                        out_count_d   = cnt_d;
                        out_carries_d = cry_d;
                    end else begin
                        state_d = ST_ACC;
                    end
                end else begin
                    state_d = ST_ACC;
                end
            end
            ST_HOLD: begin
                if (out_ready) begin
                    state_d       = ST_ACC;
                    acc_d         = 64'd0;
                    cnt_d         = '0;
                    cry_d         = '0;
                    out_valid_d   = 1'b0;
                    out_sum_d     = 64'd0;
                    out_count_d   = '0;
                    out_carries_d = '0;
                end else begin
                    state_d = ST_HOLD;
                end
            end
            default: begin
                state_d       = ST_ACC;
                acc_d         = 64'd0;
                cnt_d         = '0;
                cry_d         = '0;
                out_valid_d   = 1'b0;
                out_sum_d     = 64'd0;
                out_count_d   = '0;
                out_carries_d = '0;
            end
        endcase
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= ST_ACC;
            acc_q         <= 64'd0;
            cnt_q         <= '0;
            cry_q         <= '0;
            out_valid_q   <= 1'b0;
            out_sum_q     <= 64'd0;
            out_count_q   <= '0;
            out_carries_q <= '0;
        end else begin
            state_q       <= state_d;
            acc_q         <= acc_d;
            cnt_q         <= cnt_d;
            cry_q         <= cry_d;
            out_valid_q   <= out_valid_d;
            out_sum_q     <= out_sum_d;
            out_count_q   <= out_count_d;
            out_carries_q <= out_carries_d;
        end
    end

    assign out_valid   = out_valid_q;
    assign out_sum     = out_sum_q;
    assign out_count   = out_count_q;
    assign out_carries = out_carries_q;

endmodule

// File: tb/tb_accum64.sv
// Self-checking bench for accum64: directed scenarios plus randomized packets against a wide-arithmetic model.
module tb_accum64;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    logic        rst_n;
    logic        in_valid, in_ready, in_last, out_valid, out_ready;
    logic [63:0] in_data, out_sum;
    logic [15:0] out_count, out_carries;

    logic        s_in_valid, s_in_ready, s_in_last, s_out_valid, s_out_ready;
    logic [63:0] s_in_data, s_out_sum;
    logic [3:0]  s_out_count, s_out_carries;

    accum64 #(.CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum),
        .out_count(out_count), .out_carries(out_carries)
    );

    accum64 #(.CNT_W(4)) dut_small (
        .clk(clk), .rst_n(rst_n),
        .in_valid(s_in_valid), .in_ready(s_in_ready), .in_data(s_in_data), .in_last(s_in_last),
        .out_valid(s_out_valid), .out_ready(s_out_ready), .out_sum(s_out_sum),
        .out_count(s_out_count), .out_carries(s_out_carries)
    );

    // Reference: exact 65-bit sums, plain saturating integer counts.
    function automatic void model(input logic [63:0] q[$], input int cmax,
                                  output logic [63:0] s, output int c, output int cy);
        logic [64:0] t;
        s = 64'd0; c = 0; cy = 0;
        foreach (q[i]) begin
            t = {1'b0, s} + {1'b0, q[i]};
            if (c < cmax) c++;
            if (t[64] && cy < cmax) cy++;
`ifdef ACCUM64_SAT_EN
            s = t[64] ? 64'hFFFF_FFFF_FFFF_FFFF : t[63:0];
`else
            s = t[63:0];
`endif
        end
    endfunction

    task automatic drive_beat(input logic [63:0] d, input logic last);
        int budget = 0;
        @(negedge clk);
        in_valid = 1'b1; in_data = d; in_last = last;
        while (in_ready !== 1'b1 && budget < 50) begin
            @(negedge clk);
            budget++;
        end
        if (in_ready !== 1'b1) begin
            vectors++; miscompares++;
            $display("FAIL accept_timeout in_ready=%b required 1", in_ready);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0; in_last = 1'b0;
    endtask

    // Called right after the last beat's accepting edge; checks the result then drains it.
    task automatic drain_and_check(input logic [63:0] es, input int ec, input int ecy, input string tag);
        @(negedge clk);
        vectors++;
        if (out_valid !== 1'b1) begin miscompares++; $display("FAIL %s_valid got=%b exp=1", tag, out_valid); end
        vectors++;
        if (out_sum !== es) begin miscompares++; $display("FAIL %s_sum got=%h exp=%h", tag, out_sum, es); end
        vectors++;
        if (out_count !== ec[15:0]) begin miscompares++; $display("FAIL %s_count got=%0d exp=%0d", tag, out_count, ec); end
        vectors++;
        if (out_carries !== ecy[15:0]) begin miscompares++; $display("FAIL %s_carries got=%0d exp=%0d", tag, out_carries, ecy); end
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        @(negedge clk);
        vectors++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_sum !== 64'd0 || out_count !== 16'd0) begin
            miscompares++;
            $display("FAIL %s_drain valid=%b ready=%b sum=%h count=%0d exp 0/1/0/0", tag, out_valid, in_ready, out_sum, out_count);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        vectors++;
        if (out_valid !== 1'b0 || out_sum !== 64'd0 || out_count !== 16'd0 || out_carries !== 16'd0 || in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_state valid=%b sum=%h count=%0d carries=%0d ready=%b exp 0/0/0/0/1",
                     out_valid, out_sum, out_count, out_carries, in_ready);
        end
    endtask

    task automatic test_basic();
        out_ready = 1'b1;
        drive_beat(64'd5, 1'b0);
        drive_beat(64'd7, 1'b0);
        vectors++;
        if (out_valid !== 1'b0) begin miscompares++; $display("FAIL basic_midpacket_valid got=%b exp=0", out_valid); end
        drive_beat(64'd10, 1'b1);
        out_ready = 1'b0;
        drain_and_check(64'd22, 3, 0, "basic");
    endtask

    task automatic test_wrap();
        logic [63:0] q[$];
        logic [63:0] es; int ec, ecy;
        q = '{64'hFFFF_FFFF_FFFF_FFFF, 64'd2};
        model(q, 65535, es, ec, ecy);
        drive_beat(q[0], 1'b0);
        drive_beat(q[1], 1'b1);
`ifdef ACCUM64_SAT_EN
        drain_and_check(64'hFFFF_FFFF_FFFF_FFFF, 2, 1, "wrap");
`else
        drain_and_check(64'd1, 2, 1, "wrap");
`endif
        vectors++;
        if (es !== q[0] + q[1] && es !== 64'hFFFF_FFFF_FFFF_FFFF) begin miscompares++; $display("FAIL wrap_model got=%h", es); end
    endtask

    task automatic test_single();
        drive_beat(64'd42, 1'b1);
        drain_and_check(64'd42, 1, 0, "single");
    endtask

    task automatic test_backpressure();
        logic [63:0] held;
        drive_beat(64'd1, 1'b0);
        drive_beat(64'd2, 1'b1);
        @(negedge clk);
        in_valid = 1'b1; in_data = 64'd99; in_last = 1'b0;
        held = out_sum;
        for (int i = 0; i < 5; i++) begin
            vectors++;
            if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_sum !== 64'd3 || out_count !== 16'd2) begin
                miscompares++;
                $display("FAIL bp_hold cyc=%0d ready=%b valid=%b sum=%h count=%0d exp 0/1/3/2", i, in_ready, out_valid, out_sum, out_count);
            end
            @(negedge clk);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        @(negedge clk);
        vectors++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL bp_turnaround ready=%b valid=%b exp 1/0", in_ready, out_valid);
        end
        @(posedge clk);
        #1 in_valid = 1'b0;
        drive_beat(64'd1, 1'b1);
        drain_and_check(64'd100, 2, 0, "bp_next");
        vectors++;
        if (held !== 64'd3) begin miscompares++; $display("FAIL bp_held got=%h exp=3", held); end
    endtask

    task automatic test_random();
        for (int p = 0; p < 8; p++) begin
            logic [63:0] q[$];
            logic [63:0] es, d; int ec, ecy, len, wait_c;
            q = {};
            len = $urandom_range(1, 8);
            for (int b = 0; b < len; b++) begin
                d = {$urandom, $urandom};
                if ($urandom_range(0, 2) == 0) d = d | 64'hF000_0000_0000_0000;
                q.push_back(d);
            end
            model(q, 65535, es, ec, ecy);
            for (int b = 0; b < len; b++) begin
                drive_beat(q[b], (b == len - 1) ? 1'b1 : 1'b0);
                if (b != len - 1) begin
                    repeat ($urandom_range(0, 2)) @(negedge clk);
                end
            end
            wait_c = $urandom_range(0, 3);
            for (int w = 0; w < wait_c; w++) begin
                @(negedge clk);
                in_valid = 1'b1; in_data = {$urandom, $urandom};
                vectors++;
                if (in_ready !== 1'b0 || out_sum !== es) begin
                    miscompares++;
                    $display("FAIL rand_stall pkt=%0d ready=%b sum=%h exp 0/%h", p, in_ready, out_sum, es);
                end
            end
            in_valid = 1'b0;
            #1;
            drain_and_check(es, ec, ecy, "rand");
        end
    endtask

    task automatic test_cnt_sat();
        int budget = 0;
        for (int b = 0; b < 20; b++) begin
            @(negedge clk);
            s_in_valid = 1'b1; s_in_data = 64'd1; s_in_last = (b == 19) ? 1'b1 : 1'b0;
            if (s_in_ready !== 1'b1) begin
                vectors++; miscompares++;
                $display("FAIL sat_ready beat=%0d got=%b exp=1", b, s_in_ready);
            end
            @(posedge clk);
            #1;
        end
        s_in_valid = 1'b0; s_in_last = 1'b0;
        @(negedge clk);
        vectors++;
        if (s_out_valid !== 1'b1 || s_out_count !== 4'd15 || s_out_sum !== 64'd20 || s_out_carries !== 4'd0) begin
            miscompares++;
            $display("FAIL cnt_sat valid=%b count=%0d sum=%0d carries=%0d exp 1/15/20/0", s_out_valid, s_out_count, s_out_sum, s_out_carries);
        end
        s_out_ready = 1'b1;
        @(posedge clk);
        #1 s_out_ready = 1'b0;
        while (s_out_valid !== 1'b0 && budget < 10) begin @(negedge clk); budget++; end
    endtask

    task automatic test_reset_mid();
        drive_beat(64'd11, 1'b0);
        drive_beat(64'd12, 1'b0);
        rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        vectors++;
        if (out_valid !== 1'b0 || out_sum !== 64'd0 || out_count !== 16'd0 || out_carries !== 16'd0) begin
            miscompares++;
            $display("FAIL reset_mid valid=%b sum=%h count=%0d exp all 0", out_valid, out_sum, out_count);
        end
        drive_beat(64'd3, 1'b0);
        drive_beat(64'd4, 1'b1);
        drain_and_check(64'd7, 2, 0, "after_reset");
        drive_beat(64'd8, 1'b1);
        rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        vectors++;
        if (out_valid !== 1'b0 || out_sum !== 64'd0 || in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_hold valid=%b sum=%h ready=%b exp 0/0/1", out_valid, out_sum, in_ready);
        end
    endtask

    initial begin
        in_valid = 1'b0; in_data = 64'd0; in_last = 1'b0; out_ready = 1'b0;
        s_in_valid = 1'b0; s_in_data = 64'd0; s_in_last = 1'b0; s_out_ready = 1'b0;
        rst_n = 1'b0;
        test_reset();
        test_basic();
        test_wrap();
        test_single();
        test_backpressure();
        test_random();
        test_cnt_sat();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
